// File: rtl/data_mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_resp
// Brief    : Multi-cycle data memory that freezes the pipeline for LATENCY
//            cycles per access and pulses err_o on malformed requests.
// Revision : 1.0
// ============================================================================
module data_mem_resp #(
  parameter int LATENCY = 3,
  parameter int DEPTH   = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        stall_o,
  output logic        err_o
);

  localparam int         IDX_W      = $clog2(DEPTH);
  localparam logic [3:0] c_cnt_init = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [3:0]         r_cnt;
  logic [3:0]         w_next_cnt;
  logic               r_wr;
  logic [IDX_W-1:0]   r_idx;
  logic [31:0]        r_wdata;
  logic [31:0]        r_mem [DEPTH];

  logic               w_req_any;
  logic               w_valid;
  logic               w_start;
  logic               w_stall;
  logic               w_commit;
  logic               w_acc_wr;
  logic [IDX_W-1:0]   w_acc_idx;
  logic [31:0]        w_acc_data;

  assign w_req_any = MemRead_i | MemWrite_i;
  assign w_valid   = (MemRead_i ^ MemWrite_i) && (addr_i[1:0] == 2'b00) &&
                     (addr_i[31:2] < 30'(DEPTH));
  assign w_start   = (r_state == S_IDLE) && w_valid;

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_stall      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_valid) begin
          w_stall = 1'b1;
          if (LATENCY == 1) begin
            w_next_state = S_DONE;
            w_next_cnt   = 4'd0;
          end else begin
            w_next_state = S_BUSY;
            w_next_cnt   = c_cnt_init;
          end
        end
      end
      S_BUSY: begin
        w_stall = 1'b1;
        if (r_cnt == 4'd0) begin
          w_next_state = S_DONE;
        end else begin
          w_next_cnt = r_cnt - 4'd1;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
        w_next_cnt   = 4'd0;
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_cnt   = 4'd0;
      end
    endcase
  end

  // A single-cycle access completes straight from IDLE, so use live inputs there.
  assign w_acc_wr   = (r_state == S_IDLE) ? MemWrite_i : r_wr;
  assign w_acc_idx  = (r_state == S_IDLE) ? addr_i[IDX_W+1:2] : r_idx;
  assign w_acc_data = (r_state == S_IDLE) ? data_i : r_wdata;
  assign w_commit   = rst_i && (r_state != S_DONE) && (w_next_state == S_DONE);
  assign stall_o    = rst_i & w_stall;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_wr    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= 32'd0;
      data_o  <= 32'd0;
      err_o   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (w_start) begin
        r_wr    <= MemWrite_i;
        r_idx   <= addr_i[IDX_W+1:2];
        r_wdata <= data_i;
      end
      if (w_commit && !w_acc_wr) begin
        data_o <= r_mem[w_acc_idx];
      end
      err_o <= (r_state == S_IDLE) && w_req_any && !w_valid;
    end
  end

  // Storage is deliberately left out of reset so contents survive an abort.
  always_ff @(posedge clk_i) begin
    if (w_commit && w_acc_wr) begin
      r_mem[w_acc_idx] <= w_acc_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_resp
// Brief    : Scoreboard bench for data_mem_resp (LATENCY=3 and LATENCY=1).
// Revision : 1.0
// ============================================================================
module tb_data_mem_resp;

  localparam int LAT   = 3;
  localparam int K_WR  = 0;
  localparam int K_RD  = 1;
  localparam int K_ERR = 2;

  typedef struct {
    int          kind;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd, wr, rd1, wr1;
  logic [31:0] addr, din, addr1, din1;
  logic [31:0] dout, dout1;
  logic        stall, stall1, err, err1;

  int          checks = 0;
  int          failures = 0;
  int          run = 0;
  exp_t        q[$];
  logic [31:0] mdl [int];
  logic [31:0] mdl_dout;

  always #5 clk = ~clk;

  data_mem_resp #(.LATENCY(LAT), .DEPTH(256)) dut (
    .clk_i(clk), .rst_i(rst_n), .MemRead_i(rd), .MemWrite_i(wr),
    .addr_i(addr), .data_i(din), .data_o(dout), .stall_o(stall), .err_o(err)
  );

  data_mem_resp #(.LATENCY(1), .DEPTH(256)) dut1 (
    .clk_i(clk), .rst_i(rst_n), .MemRead_i(rd1), .MemWrite_i(wr1),
    .addr_i(addr1), .data_i(din1), .data_o(dout1), .stall_o(stall1), .err_o(err1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: a falling stall marks a completed access, err_o marks a rejection.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      run = 0;
    end else begin
      if (stall) begin
        run++;
      end else if (run > 0) begin
        if (q.size() == 0) begin
          chk("unexpected_completion", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("done_kind_not_err", 32'(e.kind == K_ERR), 32'd0);
          chk("stall_length", 32'(run), 32'(LAT));
          chk("data_o_at_done", dout, e.val);
        end
        run = 0;
      end
      if (err) begin
        if (q.size() == 0) begin
          chk("unexpected_err", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("err_kind", 32'(e.kind), 32'(K_ERR));
        end
      end
    end
  end

  task automatic do_access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    bit done = 0;
    if (r) begin
      mdl_dout = mdl[int'(a >> 2)];
      q.push_back('{K_RD, mdl_dout});
    end else begin
      q.push_back('{K_WR, mdl_dout});
      mdl[int'(a >> 2)] = d;
    end
    @(posedge clk); #1;
    rd = r; wr = w; addr = a; din = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!stall) begin
        done = 1;
        break;
      end
    end
    if (!done) chk("stall_timeout", 32'd1, 32'd0);
    #1;
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic bad_req(input logic r, input logic w, input logic [31:0] a, input int hold);
    for (int h = 0; h < hold; h++) q.push_back('{K_ERR, 32'd0});
    @(posedge clk); #1;
    rd = r; wr = w; addr = a; din = 32'h1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("bad_req_no_stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
    end
    rd = 1'b0; wr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    rd = 1'b1; wr = 1'b0; addr = 32'h0; din = 32'h0;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = 32'h0; din1 = 32'h0;
    mdl_dout = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_data", dout, 32'h0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_data_l1", dout1, 32'h0);
    rd = 1'b0;
    #1 rst_n = 1'b1;

    do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_retrigger_stall", 32'(stall), 32'd0);
    end
    do_access(1'b1, 1'b0, 32'h10, 32'h0);
    repeat (2) @(negedge clk);
    chk("read_data_held", dout, 32'hDEADBEEF);
    do_access(1'b0, 1'b1, 32'h08, 32'h12345678);
    bad_req(1'b0, 1'b1, 32'h13, 1);
    do_access(1'b1, 1'b0, 32'h10, 32'h0);
    bad_req(1'b1, 1'b1, 32'h10, 1);
    bad_req(1'b1, 1'b0, 32'h400, 3);
    do_access(1'b1, 1'b0, 32'h08, 32'h0);
    do_access(1'b0, 1'b1, 32'h20, 32'h11223344);

    // Single-cycle instance
    @(posedge clk); #1;
    wr1 = 1'b1; addr1 = 32'h0; din1 = 32'hA5A5A5A5;
    @(negedge clk); chk("l1_write_stall", 32'(stall1), 32'd1);
    @(negedge clk); chk("l1_write_done_stall", 32'(stall1), 32'd0);
    #1 wr1 = 1'b0;
    @(posedge clk); #1 rd1 = 1'b1;
    @(negedge clk); chk("l1_read_stall", 32'(stall1), 32'd1);
    @(negedge clk); chk("l1_read_done_stall", 32'(stall1), 32'd0);
    chk("l1_read_data", dout1, 32'hA5A5A5A5);
    #1 rd1 = 1'b0;
    @(negedge clk);
    chk("l1_idle_stall", 32'(stall1), 32'd0);
    chk("l1_data_held", dout1, 32'hA5A5A5A5);

    // Abort a write mid-BUSY with reset, request still held
    @(posedge clk); #1;
    wr = 1'b1; addr = 32'h20; din = 32'h55;
    @(negedge clk); chk("abort_stall_idle", 32'(stall), 32'd1);
    @(negedge clk); chk("abort_stall_busy", 32'(stall), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_stall", 32'(stall), 32'd0);
    chk("abort_data", dout, 32'h0);
    chk("abort_err", 32'(err), 32'd0);
    @(negedge clk);
    chk("abort_stall_held_req", 32'(stall), 32'd0);
    wr = 1'b0;
    #1 rst_n = 1'b1;
    mdl_dout = 32'h0;
    do_access(1'b1, 1'b0, 32'h20, 32'h0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameter LATENCY, default 3, SHALL set the number of stall cycles per access (legal range 1..15).
REQ-002 Parameter DEPTH, default 256, SHALL set the number of 32-bit words in the storage array (power of two, 16..1024).
REQ-003 clk_i  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_i  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 MemRead_i  input  1  SHALL be the read request from the MEM-stage pipeline register.
REQ-006 MemWrite_i  input  1  SHALL be the write request from the MEM-stage pipeline register.
REQ-007 addr_i  input  32  SHALL be the byte address (ALU result).
REQ-008 data_i  input  32  SHALL be the store data.
REQ-009 data_o  output  32  SHALL be the registered load data.
REQ-010 stall_o  output  1  SHALL be the pipeline freeze request.
REQ-011 err_o  output  1  SHALL be a registered one-cycle error pulse.

Function
REQ-012 FSM states SHALL be IDLE, BUSY and DONE, with a 4-bit down-counter cnt.
REQ-013 A request is valid when exactly one of MemRead_i/MemWrite_i is 1, addr_i[1:0]==0 and addr_i[31:2] < DEPTH.
REQ-014 In IDLE with a valid request, stall_o SHALL be 1 combinationally in that same cycle; the FSM SHALL capture op, word index addr_i[31:2] and data_i.
REQ-015 From IDLE with a valid request: if LATENCY==1, next state SHALL be DONE; otherwise next state SHALL be BUSY with cnt=LATENCY-2.
REQ-016 In BUSY, stall_o SHALL be 1; cnt SHALL decrement each cycle; at cnt==0 next state SHALL be DONE.
REQ-017 On the edge entering DONE, a write SHALL update mem[index] with captured data, and a read SHALL load data_o with mem[index].
REQ-018 In DONE, stall_o SHALL be 0, request inputs SHALL be ignored, and next state SHALL be IDLE, so a held request never retriggers.
REQ-019 Every access SHALL have stall_o high for exactly LATENCY consecutive cycles, followed by exactly one DONE cycle.
REQ-020 Request inputs SHALL be ignored while in BUSY; the captured values SHALL be used.
REQ-021 data_o SHALL hold its value except on read completion; writes SHALL NOT change data_o.
REQ-022 In IDLE, an invalid request (both strobes set, misaligned, or out of range) SHALL cause no access and no stall, and SHALL drive err_o=1 for the following cycle only.
REQ-023 A held invalid request SHALL produce err_o=1 on every cycle it is held after the first.
REQ-024 In IDLE with no request, stall_o SHALL be 0 and err_o SHALL be 0 next cycle.
REQ-025 A read of a word written earlier SHALL return the last written value; a back-to-back access after DONE SHALL start normally from IDLE.

Reset
REQ-026 While rst_i==0, state SHALL be IDLE, cnt=0, data_o=0, err_o=0, and stall_o=0, regardless of clock.
REQ-027 Reset asserted mid-access SHALL abort the access with no memory update; storage contents SHALL NOT be reset.
REQ-028 After release, the first rising edge SHALL accept a request in IDLE.

Verification
REQ-029 LATENCY=3; write 0xDEADBEEF to addr 0x10, held until stall_o falls -> stall_o high for 3 cycles, then 1 DONE cycle, then no further stall while the request is removed.
REQ-030 Read addr 0x10 afterwards -> stall_o high for 3 cycles; data_o=0xDEADBEEF from the DONE cycle onward and held after.
REQ-031 Write 0x1 to addr 0x13 (misaligned) -> stall_o=0, err_o=1 one cycle later, and a subsequent read of word 4 is unchanged.
REQ-032 MemRead_i=MemWrite_i=1, and a separate access to addr 4*DEPTH -> err_o pulse each, no stall.
REQ-033 Assert rst_i=0 during BUSY of a write of 0x55 to addr 0x20 -> stall_o=0 and data_o=0 immediately; a later read of 0x20 does not return 0x55 (it returns the pre-reset value).
REQ-034 LATENCY=1 build; read addr 0x0 after writing 0xA5A5A5A5 -> stall_o high for exactly 1 cycle and data_o=0xA5A5A5A5 in DONE.
